// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand widths, op codes and driver FSM state encodings.
// No logic; pure typedefs and constants.
// Used by the ALU and by the command-side driver so both agree on encodings.
package alu_pkg;
  localparam int ALU_W   = 4;
  localparam int ALU_SHW = 2;

  localparam logic [1:0] OP_SRA = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU: arith/logic shift right, wrap-around sub/add.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int SHW   = ALU_SHW
) (
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   in_c,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] ans
);

  always_comb begin
    ans = '0;
    case (op)
      OP_SRA: ans = WIDTH'($signed(in_a) >>> in_c);
      OP_SRL: ans = in_a >> in_c;
      OP_SUB: ans = in_a - in_b;
      OP_ADD: ans = in_a + in_b;
      default: ans = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_driver.sv
// Command-side initiator for the ALU; RESULT_FWD_EN lets a command reuse the last result as A.
// Latency: handshake cycle starting at edge N -> rsp_valid high after edge N+2.
// Backpressure: no skid; cmd_ready low in EXEC/RESP, all outputs frozen while rsp_ready is low.
module alu_seq_driver
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int SHW   = ALU_SHW,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SHW-1:0]   cmd_sh,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_fwd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SHW-1:0]   alu_c,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_ans,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [CNTW-1:0]  ops_done
);

  state_e           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SHW-1:0]   alu_c_q, alu_c_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [CNTW-1:0]  ops_done_q, ops_done_d;
  logic [WIDTH-1:0] last_result_q, last_result_d;
  logic [WIDTH-1:0] a_sel;

`ifdef RESULT_FWD_EN
  assign a_sel = cmd_fwd ? last_result_q : cmd_a;
`else
  logic unused_fwd;
  assign unused_fwd = cmd_fwd ^ (^last_result_q);
  assign a_sel      = cmd_a;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_c_d       = alu_c_q;
    alu_op_d      = alu_op_q;
    ops_done_d    = ops_done_q;
    last_result_d = last_result_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d     = a_sel;
          alu_b_d     = cmd_b;
          alu_c_d     = cmd_sh;
          alu_op_d    = cmd_op;
          cmd_ready_d = 1'b0;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // ALU has had a full cycle to settle on the registered operands
        rsp_data_d    = alu_ans;
        last_result_d = alu_ans;
        rsp_valid_d   = 1'b1;
        state_d       = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + CNTW'(1);
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_c_q       <= '0;
      alu_op_q      <= '0;
      ops_done_q    <= '0;
      last_result_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_c_q       <= alu_c_d;
      alu_op_q      <= alu_op_d;
      ops_done_q    <= ops_done_d;
      last_result_q <= last_result_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_c     = alu_c_q;
  assign alu_op    = alu_op_q;
  assign ops_done  = ops_done_q;

endmodule
